// File: rtl/aes_inv_key_schedule.sv
// AES-128 key expansion: stores all 11 round keys and serves them with 1-cycle registered reads.
// Define AES_KS_INV_ORDER_EN to read keys in decryption order (rk_idx=0 returns round key 10).
module aes_inv_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_valid
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  localparam logic [0:15][127:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    row = SBOX[b[7:4]];
    return row[8 * (15 - int'(b[3:0])) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state_q;
  logic [3:0]   rnd_q;
  logic         done_q;
  logic [127:0] rk_mem [0:10];
  // Copy of the last round key, so expansion never needs a read port on rk_mem.
  logic [127:0] cur_q;
  logic [127:0] nxt_key;
  logic [31:0]  w0, w1, w2, w3, tmp;
  logic         xfer;
  logic         rd_ok;
  logic [3:0]   rd_sel;

  assign key_ready = (state_q != EXPAND);
  assign busy      = (state_q == EXPAND);
  assign done      = done_q;
  assign xfer      = key_valid && key_ready;

  always_comb begin
    w3  = cur_q[31:0];
    tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
          ^ {rcon(rnd_q), 24'h0};
    w0  = cur_q[127:96] ^ tmp;
    w1  = cur_q[95:64]  ^ w0;
    w2  = cur_q[63:32]  ^ w1;
    nxt_key = {w0, w1, w2, w3 ^ w2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        EXPAND: begin
          if (rnd_q == 4'd10) begin
            state_q <= READY;
            rnd_q   <= 4'd0;
            done_q  <= 1'b1;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        default: begin
          if (xfer) begin
            state_q <= EXPAND;
            rnd_q   <= 4'd1;
          end
        end
      endcase
    end
  end

  // Key storage survives reset; it is only ever overwritten.
  always_ff @(posedge clk) begin
    if (xfer) begin
      rk_mem[0] <= key_in;
      cur_q     <= key_in;
    end else if (state_q == EXPAND) begin
      rk_mem[rnd_q] <= nxt_key;
      cur_q         <= nxt_key;
    end
  end

  assign rd_ok = (rk_idx <= 4'd10);
`ifdef AES_KS_INV_ORDER_EN
  assign rd_sel = 4'd10 - rk_idx;
`else
  assign rd_sel = rk_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out   <= 128'h0;
      rk_valid <= 1'b0;
    end else begin
      rk_out   <= rd_ok ? rk_mem[rd_sel] : 128'h0;
      rk_valid <= (state_q == READY) && !xfer && rd_ok;
    end
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule using FIPS-197 key expansion vectors and a read scoreboard.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready, busy, done;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_valid;

  int total = 0;
  int bad   = 0;
  int cyc;

  typedef struct {
    logic [127:0] key;
    logic         vld;
    bit           chk_key;
    string        tag;
  } exp_t;
  exp_t sbq[$];

  localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KB = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KB10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic [127:0] a_keys [0:10];

  aes_inv_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .busy(busy), .done(done), .rk_idx(rk_idx),
    .rk_out(rk_out), .rk_valid(rk_valid)
  );

  always #5 clk = ~clk;

  function automatic int map_idx(input int i);
`ifdef AES_KS_INV_ORDER_EN
    return 10 - i;
`else
    return i;
`endif
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one read index, expect the result one edge later.
  task automatic read_idx(input int i, input logic [127:0] k, input logic v,
                          input bit ck, input string tag);
    exp_t e;
    e.key = k; e.vld = v; e.chk_key = ck; e.tag = tag;
    sbq.push_back(e);
    rk_idx = 4'(i);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk1({e.tag, "_vld"}, rk_valid, e.vld);
    if (e.chk_key) chk128({e.tag, "_key"}, rk_out, e.key);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        chk1("exp_busy", busy, 1'b1);
        chk1("exp_key_ready", key_ready, 1'b0);
        chk1("exp_rk_valid", rk_valid, 1'b0);
      end
      if (done) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    a_keys[0]  = KA;
    a_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rk_idx = '0;
    #3;
    chk1("rst_key_ready", key_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_rk_valid", rk_valid, 1'b0);
    chk128("rst_rk_out", rk_out, 128'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    read_idx(0, '0, 1'b0, 1'b0, "idle_read");

    // Key A: latency, then full sweep 0..15.
    key_in = KA; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk1("xfer_busy", busy, 1'b1);
    wait_done(cyc);
    chkint("a_done_latency", cyc, 10);
    for (int i = 0; i < 16; i++) begin
      if (i <= 10) read_idx(i, a_keys[map_idx(i)], 1'b1, 1'b1, $sformatf("sweep%0d", i));
      else         read_idx(i, 128'h0, 1'b0, 1'b1, $sformatf("sweep%0d", i));
      if (i == 0) chk1("done_one_pulse", done, 1'b0);
    end

    // Key B accepted in READY; key_valid held with a different key_in through EXPAND.
    key_in = KB; key_valid = 1'b1;
    @(posedge clk); #1;
    key_in = KA;
    wait_done(cyc);
    chkint("b_done_latency", cyc, 10);
    key_valid = 1'b0;
    read_idx(map_idx(10), KB10, 1'b1, 1'b1, "b_rk10");
    read_idx(map_idx(0), KB, 1'b1, 1'b1, "b_rk0");

    // Re-key from READY: rk_valid must drop right after the transfer edge.
    key_in = KA; key_valid = 1'b1;
    read_idx(map_idx(10), '0, 1'b0, 1'b0, "rekey_vld_drop");
    key_valid = 1'b0;
    wait_done(cyc);
    chkint("rekey_done_latency", cyc, 10);
    read_idx(map_idx(10), a_keys[10], 1'b1, 1'b1, "rekey_rk10");

    // Reset in the middle of expansion.
    rk_idx = 4'd0;
    key_in = KB; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_key_ready", key_ready, 1'b1);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chk1("mid_rst_rk_valid", rk_valid, 1'b0);
    chk128("mid_rst_rk_out", rk_out, 128'h0);
    #1 rst_n = 1'b1;
    key_in = KA; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    wait_done(cyc);
    chkint("post_rst_latency", cyc, 10);
    read_idx(map_idx(10), a_keys[10], 1'b1, 1'b1, "post_rst_rk10");
    read_idx(map_idx(5), a_keys[5], 1'b1, 1'b1, "post_rst_rk5");
    read_idx(12, 128'h0, 1'b0, 1'b1, "post_rst_oor");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
